// File: rtl/vga_capture_pkg.sv
// vga_capture_pkg: shared definitions for the VGA capture path.
// Holds the default 640x400 source timing, the decimated output geometry,
// the capture FSM state encoding and the RGB332 pixel packing helper.
package vga_capture_pkg;

  // Default 640x400 source timing (pixels / lines)
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 400;
  localparam int V_FP     = 12;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 35;

  // Output framebuffer geometry
  localparam int OUT_W = 160;
  localparam int OUT_H = 100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

  // Pack 24-bit RGB into one RGB332 byte: {r[7:5], g[7:5], b[7:6]}
  function automatic logic [7:0] pack_rgb332(input logic [7:0] red,
                                             input logic [7:0] green,
                                             input logic [7:0] blue);
    return {red[7:5], green[7:5], blue[7:6]};
  endfunction

endpackage

// File: rtl/vga_capture_sync_detect.sv
// vga_sync_detect: registers vs/de once and derives frame/line events.
// Ports:
//   pclk, reset   pixel clock, synchronous active-high reset
//   vs, de        raw sync inputs from the pins
//   de_q          registered de
//   vs_start      registered vs just became active (polarity VS_POL)
//   line_end      registered de just fell
module vga_sync_detect #(
  parameter bit VS_POL = 1'b1
) (
  input  logic pclk,
  input  logic reset,
  input  logic vs,
  input  logic de,
  output logic de_q,
  output logic vs_start,
  output logic line_end
);

  logic vs_act_r;
  logic vs_act_d_r;
  logic de_r;
  logic de_d_r;

  // Input registration plus one extra stage for edge detection
  always_ff @(posedge pclk) begin
    if (reset) begin
      vs_act_r   <= 1'b0;
      vs_act_d_r <= 1'b0;
      de_r       <= 1'b0;
      de_d_r     <= 1'b0;
    end else begin
      // Normalise polarity so the edge detector is always rising-edge
      vs_act_r   <= (vs == VS_POL);
      vs_act_d_r <= vs_act_r;
      de_r       <= de;
      de_d_r     <= de_r;
    end
  end

  assign de_q     = de_r;
  assign vs_start = vs_act_r & ~vs_act_d_r;
  assign line_end = de_d_r & ~de_r;

endmodule

// File: rtl/vga_capture.sv
// vga_capture: decimates a 640x400 pixel stream 4x4 into a 160x100 RGB332
// framebuffer, issuing one byte write per kept pixel. Also tracks whether
// the source timing is stable (locked).
// Ports:
//   pclk, reset        pixel clock, synchronous active-high reset
//   enable             capture request, acted on at frame boundaries
//   vs, de, r, g, b    source video
//   wr, addr, data     byte write port (no backpressure)
//   busy               ARMED or CAPTURE
//   frame_done         one-cycle pulse when a captured frame ends
//   locked             two consecutive frames had the expected line count
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int          H_OUT      = OUT_W,
  parameter int          V_OUT      = OUT_H,
  parameter int          SCALE_LOG2 = 2,
  parameter bit          VS_POL     = 1'b1,
  parameter logic [31:0] ADDR_BASE  = 32'd0
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        vs,
  input  logic        de,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        wr,
  output logic [31:0] addr,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done,
  output logic        locked
);

  localparam logic [9:0]  SUB_MASK    = 10'((1 << SCALE_LOG2) - 1);
  localparam logic [31:0] FRAME_LINES = 32'(V_OUT << SCALE_LOG2);

  logic [7:0]  r_r, g_r, b_r;
  logic        de_s, vs_start_s, line_end_s;
  logic [9:0]  col_r, line_r;
  cap_state_e  state_r, state_nxt_s;
  logic        sample_s, frame_end_s;
  logic [31:0] row_s, colx_s, addr_nxt_s, lines_seen_s;
  logic        lines_ok_s, prev_ok_r;
  logic        wr_r, busy_r, frame_done_r, locked_r;
  logic [31:0] addr_r;
  logic [7:0]  data_r;

  vga_sync_detect #(
    .VS_POL(VS_POL)
  ) u_sync (
    .pclk     (pclk),
    .reset    (reset),
    .vs       (vs),
    .de       (de),
    .de_q     (de_s),
    .vs_start (vs_start_s),
    .line_end (line_end_s)
  );

  // Colour inputs registered alongside vs/de so a sample stays aligned
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_r <= 8'd0;
      g_r <= 8'd0;
      b_r <= 8'd0;
    end else begin
      r_r <= r;
      g_r <= g;
      b_r <= b;
    end
  end

  // Column/line position of the registered pixel
  always_ff @(posedge pclk) begin
    if (reset) begin
      col_r  <= 10'd0;
      line_r <= 10'd0;
    end else begin
      if (line_end_s) begin
        col_r <= 10'd0;
      end else if (de_s) begin
        col_r <= col_r + 10'd1;
      end else begin
        col_r <= col_r;
      end
      // vs_start wins: a coincident line_end is folded into lines_seen_s
      if (vs_start_s) begin
        line_r <= 10'd0;
      end else if (line_end_s) begin
        line_r <= line_r + 10'd1;
      end else begin
        line_r <= line_r;
      end
    end
  end

  // Sample decision, write address and frame line count
  always_comb begin
    row_s        = 32'(line_r >> SCALE_LOG2);
    colx_s       = 32'(col_r >> SCALE_LOG2);
    addr_nxt_s   = ADDR_BASE + row_s * 32'(H_OUT) + colx_s;
    if ((state_r == ST_CAPTURE) && de_s &&
        ((col_r & SUB_MASK) == 10'd0) && ((line_r & SUB_MASK) == 10'd0) &&
        (colx_s < 32'(H_OUT)) && (row_s < 32'(V_OUT))) begin
      sample_s = 1'b1;
    end else begin
      sample_s = 1'b0;
    end
    lines_seen_s = 32'(line_r) + (line_end_s ? 32'd1 : 32'd0);
    lines_ok_s   = (lines_seen_s == FRAME_LINES);
  end

  // Capture FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    frame_end_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!enable) begin
          state_nxt_s = ST_IDLE;
        end else if (vs_start_s) begin
          state_nxt_s = ST_CAPTURE;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        // enable is only consulted here, so a mid-frame drop finishes the frame
        if (vs_start_s) begin
          frame_end_s = 1'b1;
          if (enable) begin
            state_nxt_s = ST_CAPTURE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered write port and status outputs
  always_ff @(posedge pclk) begin
    if (reset) begin
      wr_r         <= 1'b0;
      addr_r       <= 32'd0;
      data_r       <= 8'd0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      wr_r         <= sample_s;
      busy_r       <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_CAPTURE);
      frame_done_r <= frame_end_s;
      if (sample_s) begin
        addr_r <= addr_nxt_s;
        data_r <= pack_rgb332(r_r, g_r, b_r);
      end else begin
        addr_r <= addr_r;
        data_r <= data_r;
      end
    end
  end

  // Lock tracking runs in every state: needs two good frames in a row
  always_ff @(posedge pclk) begin
    if (reset) begin
      prev_ok_r <= 1'b0;
      locked_r  <= 1'b0;
    end else if (vs_start_s) begin
      prev_ok_r <= lines_ok_s;
      locked_r  <= lines_ok_s & prev_ok_r;
    end else begin
      prev_ok_r <= prev_ok_r;
      locked_r  <= locked_r;
    end
  end

  assign wr         = wr_r;
  assign addr       = addr_r;
  assign data       = data_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign locked     = locked_r;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed frames drive the capture block; the driver pushes
// expected writes into a queue and a negedge monitor pops and compares them.
module tb_vga_capture;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } exp_t;

  logic        pclk;
  logic        reset;
  logic        enable;
  logic        vs;
  logic        de;
  logic [7:0]  r, g, b;
  logic        wr;
  logic [31:0] addr;
  logic [7:0]  data;
  logic        busy;
  logic        frame_done;
  logic        locked;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   fd_cnt = 0;
  int   lat_de_cyc = 0;
  int   lat_wr_cyc = -100;
  bit   lat_arm = 1'b0;
  exp_t exp_q[$];

  vga_capture dut (
    .pclk       (pclk),
    .reset      (reset),
    .enable     (enable),
    .vs         (vs),
    .de         (de),
    .r          (r),
    .g          (g),
    .b          (b),
    .wr         (wr),
    .addr       (addr),
    .data       (data),
    .busy       (busy),
    .frame_done (frame_done),
    .locked     (locked)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Cycle counter, advanced on each active edge
  initial forever begin
    @(posedge pclk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] pack_ref(input logic [7:0] rr, input logic [7:0] gg,
                                          input logic [7:0] bb);
    return {rr[7:5], gg[7:5], bb[7:6]};
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every write, counts frame_done pulses
  initial forever begin
    exp_t e;
    @(negedge pclk);
    if (wr === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      if (lat_arm) begin
        lat_wr_cyc = cyc;
        lat_arm    = 1'b0;
      end
      if (exp_q.size() == 0) begin
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL unexpected_wr actual addr=%0d data=%0h expected no write", addr, data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr_data", {24'd0, addr, data}, {24'd0, e.a, e.d});
      end
    end
    if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr"}, {63'd0, wr}, 64'd0);
    chk({tag, "_addr"}, {32'd0, addr}, 64'd0);
    chk({tag, "_data"}, {56'd0, data}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
    chk({tag, "_locked"}, {63'd0, locked}, 64'd0);
  endtask

  // One frame: vsync pulse, then nl lines of nc pixels. mode 0 = x^y
  // pattern, mode 1 = constant colour. sw_line changes enable at that line,
  // rst_line pulses reset at pixel 1 of that line. exp_lock < 0 skips check.
  task automatic frame(input int nl, input int nc, input bit cap, input int mode,
                       input int sw_line, input bit sw_val, input int rst_line,
                       input int exp_lock);
    bit         cap_l;
    exp_t       e;
    logic [7:0] pr, pg, pb;
    cap_l = cap;
    de = 1'b0;
    vs = 1'b1;
    tick();
    tick();
    vs = 1'b0;
    tick();
    tick();
    tick();
    if (exp_lock >= 0) chk("locked_at_vs", {63'd0, locked}, 64'(exp_lock));
    for (int y = 0; y < nl; y++) begin
      if (y == sw_line) begin
        enable = sw_val;
        tick();
        chk("busy_after_enable_change", {63'd0, busy}, 64'd1);
      end
      if (y == rst_line) cap_l = 1'b0;
      for (int x = 0; x < nc; x++) begin
        if (mode == 1) begin
          pr = 8'hE0;
          pg = 8'h1C;
          pb = 8'hC0;
        end else begin
          pr = 8'(x ^ y);
          pg = 8'(x);
          pb = 8'(y);
        end
        r  = pr;
        g  = pg;
        b  = pb;
        de = 1'b1;
        if (mode == 1 && x == 0 && y == 0) begin
          lat_de_cyc = cyc;
          lat_arm    = 1'b1;
        end
        if (y == rst_line && x == 1) reset = 1'b1;
        if (y == rst_line && x == 2) begin
          reset = 1'b0;
          chk_all_zero("after_reset");
        end
        if (cap_l && (x % 4 == 0) && (y % 4 == 0) && (x / 4 < 160) && (y / 4 < 100)) begin
          e.a = 32'((y / 4) * 160 + (x / 4));
          e.d = (mode == 1) ? 8'hE3 : pack_ref(pr, pg, pb);
          exp_q.push_back(e);
        end
        tick();
      end
      de = 1'b0;
      tick();
      tick();
    end
    tick();
    tick();
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    vs     = 1'b0;
    de     = 1'b0;
    r      = 8'd0;
    g      = 8'd0;
    b      = 8'd0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Lock tracking with capture disabled
    frame(400, 4, 1'b0, 0, -1, 1'b0, -1, 0);
    frame(400, 4, 1'b0, 0, -1, 1'b0, -1, 0);
    frame(399, 4, 1'b0, 0, -1, 1'b0, -1, 1);
    frame(400, 4, 1'b0, 0, -1, 1'b0, -1, 0);
    chk("busy_idle", {63'd0, busy}, 64'd0);

    // Arm mid-frame: nothing written for the rest of this frame
    frame(400, 8, 1'b0, 0, 100, 1'b1, -1, 0);

    // Loopback pattern: 4 x 100 writes
    wr_cnt = 0;
    frame(400, 16, 1'b1, 0, -1, 1'b0, -1, 1);
    chk("loopback_wr_count", 64'(wr_cnt), 64'd400);
    chk("loopback_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("fd_after_first_capture", 64'(fd_cnt), 64'd0);

    // Constant colour and pin-to-wr latency
    frame(400, 16, 1'b1, 1, -1, 1'b0, -1, 1);
    chk("wr_latency", 64'(lat_wr_cyc - lat_de_cyc), 64'd2);
    chk("colour_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("fd_after_second_frame", 64'(fd_cnt), 64'd1);

    // Disable at line 200: frame still completes
    frame(400, 8, 1'b1, 0, 200, 1'b0, -1, 1);
    chk("middisable_queue_drained", 64'(exp_q.size()), 64'd0);
    frame(8, 8, 1'b0, 0, -1, 1'b0, -1, 1);
    chk("busy_after_disable", {63'd0, busy}, 64'd0);
    chk("fd_after_disable", 64'(fd_cnt), 64'd3);

    // Oversize lines (720 columns) and oversize frame (408 lines)
    enable = 1'b1;
    tick();
    wr_cnt = 0;
    frame(8, 720, 1'b1, 0, -1, 1'b0, -1, 0);
    chk("wide_wr_count", 64'(wr_cnt), 64'd320);
    frame(408, 8, 1'b1, 0, -1, 1'b0, -1, 0);
    chk("tall_queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset on a sample cycle at line 200, then a fresh capture
    frame(400, 8, 1'b1, 0, -1, 1'b0, 200, 0);
    chk("reset_queue_drained", 64'(exp_q.size()), 64'd0);
    wr_cnt = 0;
    frame(400, 8, 1'b1, 0, -1, 1'b0, -1, 0);
    chk("recapture_wr_count", 64'(wr_cnt), 64'd200);
    enable = 1'b0;
    frame(4, 8, 1'b0, 0, -1, 1'b0, -1, 0);
    repeat (4) tick();
    chk("fd_total", 64'(fd_cnt), 64'd6);
    chk("busy_final", {63'd0, busy}, 64'd0);
    chk("final_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
